sd_spi_init_sequencer: RTL and testbench

Drives an SD card in SPI mode through its power-up initialisation: 80 dummy clocks, then CMD0, CMD8, and the CMD55/ACMD41 loop until the card leaves idle. It sits between the board buttons/top-level control and the SD card pins, and replaces ad-hoc clock gating with a self-timed SPI master running at 250 kHz from `CLOCK_50`. On completion it flags success or a coded error, and holds the last R1 response for debug display.

---
 rtl/sd_spi_init_sequencer.sv | 236 +++++++++++++++++++++++
 tb/tb_sd_spi_init_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_spi_init_sequencer.sv
// SD card SPI-mode power-up sequencer: dummy clocks, CMD0, CMD8/R7, then the
// CMD55/ACMD41 loop, with a self-timed mode-0 SPI bit engine.
module sd_spi_init_sequencer #(
    parameter int CLK_DIV      = 100,
    parameter int DUMMY_CLKS   = 80,
    parameter int RESP_TIMEOUT = 16,
    parameter int MAX_RETRY    = 255
) (
    input  logic       CLOCK_50,
    input  logic       rst_n,
    input  logic       start,
    input  logic       sd_miso,
    output logic       sd_sclk,
    output logic       sd_cs_n,
    output logic       sd_mosi,
    output logic       busy,
    output logic       init_done,
    output logic       init_err,
    output logic [2:0] err_code,
    output logic [7:0] last_r1
);
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_DUMMY     = 3'd1;
    localparam logic [2:0] S_CMD_SEND  = 3'd2;
    localparam logic [2:0] S_RESP_WAIT = 3'd3;
    localparam logic [2:0] S_R7_READ   = 3'd4;
    localparam logic [2:0] S_GAP       = 3'd5;
    localparam logic [2:0] S_DONE      = 3'd6;
    localparam logic [2:0] S_ERR       = 3'd7;

    localparam logic [1:0] C_CMD0   = 2'd0;
    localparam logic [1:0] C_CMD8   = 2'd1;
    localparam logic [1:0] C_CMD55  = 2'd2;
    localparam logic [1:0] C_ACMD41 = 2'd3;

    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int CNT_W = 16;

    logic [2:0]       state;
    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       tx_sr;
    logic [7:0]       rx_sr;
    logic             rx_byte;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       byte_idx;
    logic [1:0]       cmd;
    logic [7:0]       retry_cnt;
    logic [1:0]       gap_cmd;
    logic             gap_done;
    logic [2:0]       gap_err;

    logic tick, rise, fall, byte_end;
    logic [1:0] res_cmd;
    logic       res_done;
    logic [2:0] res_err;

    // Half-period counter only runs while busy, so SCLK parks low when idle.
    assign tick     = busy && (div_cnt == '0);
    assign rise     = tick && !sd_sclk;
    assign fall     = tick && sd_sclk;
    assign byte_end = fall && (bit_cnt == 3'd7);
    assign sd_mosi  = tx_sr[7];

    function automatic logic [7:0] cmd_byte(input logic [1:0] c, input logic [2:0] i);
        logic [47:0] f;
        case (c)
            C_CMD0:  f = 48'h40_00_00_00_00_95;
            C_CMD8:  f = 48'h48_00_00_01_AA_87;
            C_CMD55: f = 48'h77_00_00_00_00_65;
            default: f = 48'h69_40_00_00_00_77;
        endcase
        return f[8*(5 - int'(i)) +: 8];
    endfunction

    // Verdict on the byte just received, for whichever command is in flight.
    always_comb begin
        res_cmd  = C_CMD55;
        res_done = 1'b0;
        res_err  = 3'd0;
        case (cmd)
            C_CMD0: begin
                if (rx_sr == 8'h01) res_cmd = C_CMD8;
                else                res_err = 3'd1;
            end
            C_CMD8: begin
                if (rx_sr != 8'hAA) res_err = 3'd3;
            end
            C_CMD55: begin
                if (rx_sr[7:1] == 7'd0) res_cmd = C_ACMD41;
                else                    res_err = 3'd4;
            end
            default: begin
                if (rx_sr == 8'h00)                         res_done = 1'b1;
                else if (rx_sr != 8'h01)                    res_err  = 3'd4;
                else if (retry_cnt >= 8'(MAX_RETRY - 1))    res_err  = 3'd5;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            tx_sr     <= 8'hFF;
            rx_sr     <= 8'hFF;
            rx_byte   <= 1'b0;
            cnt       <= '0;
            byte_idx  <= '0;
            cmd       <= C_CMD0;
            retry_cnt <= '0;
            gap_cmd   <= C_CMD0;
            gap_done  <= 1'b0;
            gap_err   <= '0;
            sd_sclk   <= 1'b0;
            sd_cs_n   <= 1'b1;
            busy      <= 1'b0;
            init_done <= 1'b0;
            init_err  <= 1'b0;
            err_code  <= '0;
            last_r1   <= 8'hFF;
        end else begin
            rx_byte <= 1'b0;
            if (tick) begin
                div_cnt <= DIV_W'(CLK_DIV - 1);
                sd_sclk <= ~sd_sclk;
            end else if (busy) begin
                div_cnt <= div_cnt - 1'b1;
            end
            if (rise) begin
                rx_sr   <= {rx_sr[6:0], sd_miso};
                rx_byte <= (bit_cnt == 3'd7);
            end
            if (fall) begin
                bit_cnt <= bit_cnt + 3'd1;
                tx_sr   <= {tx_sr[6:0], 1'b1};
            end
            if (rx_byte && state == S_RESP_WAIT && !rx_sr[7])
                last_r1 <= rx_sr;

            case (state)
                S_DUMMY: if (fall) begin
                    if (cnt == CNT_W'(DUMMY_CLKS - 1)) begin
                        state    <= S_CMD_SEND;
                        cmd      <= C_CMD0;
                        byte_idx <= '0;
                        bit_cnt  <= '0;
                        tx_sr    <= cmd_byte(C_CMD0, 3'd0);
                        sd_cs_n  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_CMD_SEND: if (byte_end) begin
                    if (byte_idx == 3'd5) begin
                        state <= S_RESP_WAIT;
                        cnt   <= '0;
                        tx_sr <= 8'hFF;
                    end else begin
                        byte_idx <= byte_idx + 3'd1;
                        tx_sr    <= cmd_byte(cmd, byte_idx + 3'd1);
                    end
                end
                S_RESP_WAIT: if (byte_end) begin
                    if (!rx_sr[7]) begin
                        if (cmd == C_CMD8 && rx_sr == 8'h01) begin
                            state <= S_R7_READ;
                            cnt   <= '0;
                        end else begin
                            state    <= S_GAP;
                            sd_cs_n  <= 1'b1;
                            gap_cmd  <= res_cmd;
                            gap_done <= res_done;
                            gap_err  <= (cmd == C_CMD8) ? 3'd2 : res_err;
                            if (cmd == C_ACMD41 && rx_sr == 8'h01 && retry_cnt != 8'hFF)
                                retry_cnt <= retry_cnt + 8'd1;
                        end
                    end else if (cnt == CNT_W'(RESP_TIMEOUT - 1)) begin
                        state    <= S_GAP;
                        sd_cs_n  <= 1'b1;
                        gap_done <= 1'b0;
                        gap_err  <= 3'd6;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_R7_READ: if (byte_end) begin
                    if (cnt == CNT_W'(3)) begin
                        state    <= S_GAP;
                        sd_cs_n  <= 1'b1;
                        gap_cmd  <= res_cmd;
                        gap_done <= 1'b0;
                        gap_err  <= res_err;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_GAP: if (byte_end) begin
                    if (gap_err != 3'd0) begin
                        state    <= S_ERR;
                        busy     <= 1'b0;
                        init_err <= 1'b1;
                        err_code <= gap_err;
                    end else if (gap_done) begin
                        state     <= S_DONE;
                        busy      <= 1'b0;
                        init_done <= 1'b1;
                    end else begin
                        state    <= S_CMD_SEND;
                        cmd      <= gap_cmd;
                        byte_idx <= '0;
                        tx_sr    <= cmd_byte(gap_cmd, 3'd0);
                        sd_cs_n  <= 1'b0;
                    end
                end
                default: if (start) begin
                    // IDLE, DONE and ERR: a new start clears the sticky flags.
                    state     <= S_DUMMY;
                    busy      <= 1'b1;
                    init_done <= 1'b0;
                    init_err  <= 1'b0;
                    err_code  <= '0;
                    div_cnt   <= DIV_W'(CLK_DIV);
                    bit_cnt   <= '0;
                    cnt       <= '0;
                    retry_cnt <= '0;
                    gap_err   <= '0;
                    gap_done  <= 1'b0;
                    sd_cs_n   <= 1'b1;
                    tx_sr     <= 8'hFF;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sd_spi_init_sequencer.sv
// Directed bench for sd_spi_init_sequencer with a behavioural SD card that
// logs received commands and answers from a scripted response queue.
module tb_sd_spi_init_sequencer;
    localparam int CLK_DIV = 2;
    localparam logic [47:0] EXP_NOM [8] = '{
        48'h400000000095, 48'h48000001AA87,
        48'h770000000065, 48'h694000000077,
        48'h770000000065, 48'h694000000077,
        48'h770000000065, 48'h694000000077};

    logic       CLOCK_50 = 1'b0;
    logic       rst_n, start;
    logic       sd_miso = 1'b1;
    logic       sd_sclk, sd_cs_n, sd_mosi, busy, init_done, init_err;
    logic [2:0] err_code;
    logic [7:0] last_r1;

    int total = 0;
    int bad   = 0;

    bit         cfg_silent;
    logic [7:0] cfg_echo;
    int         cfg_busy_cnt;

    sd_spi_init_sequencer #(.CLK_DIV(CLK_DIV), .DUMMY_CLKS(80), .RESP_TIMEOUT(16), .MAX_RETRY(3)) dut (
        .CLOCK_50(CLOCK_50), .rst_n(rst_n), .start(start), .sd_miso(sd_miso),
        .sd_sclk(sd_sclk), .sd_cs_n(sd_cs_n), .sd_mosi(sd_mosi), .busy(busy),
        .init_done(init_done), .init_err(init_err), .err_code(err_code), .last_r1(last_r1));

    always #5 CLOCK_50 = ~CLOCK_50;

    // Card model: samples MOSI on SCLK rise, shifts MISO on SCLK fall.
    logic [7:0]  rq [$];
    logic [47:0] cmd_log [$];
    logic [47:0] cmd_buf = '0;
    logic [7:0]  in_sr = 8'hFF, out_sr = 8'hFF;
    int          cmd_len = 0, c_bits = 0, acmd_cnt = 0, lo_rises = 0;
    logic        sclk_q = 1'b0;

    always @(negedge CLOCK_50) begin
        if (sd_cs_n) begin
            c_bits = 0; cmd_len = 0; rq.delete(); out_sr = 8'hFF; sd_miso = 1'b1;
        end else if (sd_sclk && !sclk_q) begin
            lo_rises++;
            in_sr = {in_sr[6:0], sd_mosi};
            c_bits++;
            if (c_bits == 8) begin
                c_bits = 0;
                if (cmd_len > 0 || in_sr[7:6] == 2'b01) begin
                    cmd_buf = {cmd_buf[39:0], in_sr};
                    cmd_len++;
                    if (cmd_len == 6) begin
                        cmd_len = 0;
                        cmd_log.push_back(cmd_buf);
                        case (cmd_buf[47:40])
                            8'h40: begin
                                acmd_cnt = 0;
                                if (!cfg_silent) begin rq.push_back(8'hFF); rq.push_back(8'h01); end
                            end
                            8'h48: begin
                                rq.push_back(8'hFF); rq.push_back(8'h01); rq.push_back(8'h00);
                                rq.push_back(8'h00); rq.push_back(8'h01); rq.push_back(cfg_echo);
                            end
                            8'h77: begin rq.push_back(8'hFF); rq.push_back(8'h01); end
                            8'h69: begin
                                acmd_cnt++;
                                rq.push_back(8'hFF);
                                rq.push_back((acmd_cnt > cfg_busy_cnt) ? 8'h00 : 8'h01);
                            end
                            default: ;
                        endcase
                    end
                end
            end
        end else if (!sd_sclk && sclk_q) begin
            if (c_bits == 0) out_sr = (rq.size() > 0) ? rq.pop_front() : 8'hFF;
            else             out_sr = {out_sr[6:0], 1'b1};
            sd_miso = out_sr[7];
        end
        sclk_q = sd_sclk;
    end

    task automatic pulse_start();
        @(negedge CLOCK_50); start = 1'b1;
        @(negedge CLOCK_50); start = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 20000; n++) begin
            if (!busy) begin ok = 1'b1; break; end
            @(negedge CLOCK_50);
        end
    endtask

    task automatic test_reset();
        int highs = 0;
        rst_n = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        total++; if (sd_sclk !== 1'b0)   begin bad++; $display("FAIL reset_sclk: got %b want 0", sd_sclk); end
        total++; if (sd_cs_n !== 1'b1)   begin bad++; $display("FAIL reset_cs_n: got %b want 1", sd_cs_n); end
        total++; if (sd_mosi !== 1'b1)   begin bad++; $display("FAIL reset_mosi: got %b want 1", sd_mosi); end
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if ({init_done, init_err} !== 2'b00) begin bad++; $display("FAIL reset_flags: got %b want 00", {init_done, init_err}); end
        total++; if (err_code !== 3'd0)  begin bad++; $display("FAIL reset_err_code: got %0d want 0", err_code); end
        total++; if (last_r1 !== 8'hFF)  begin bad++; $display("FAIL reset_last_r1: got %h want ff", last_r1); end
        rst_n = 1'b1;
        for (int n = 0; n < 10000; n++) begin
            @(negedge CLOCK_50);
            if (sd_sclk !== 1'b0) highs++;
        end
        total++; if (highs != 0) begin bad++; $display("FAIL idle_sclk: got %0d high cycles want 0", highs); end
    endtask

    task automatic check_cmds(input string name, input int base, input int cnt);
        total++;
        if (cmd_log.size() - base != cnt) begin
            bad++; $display("FAIL %s_cmd_count: got %0d want %0d", name, cmd_log.size() - base, cnt);
        end else begin
            for (int i = 0; i < cnt; i++) begin
                total++;
                if (cmd_log[base + i] !== EXP_NOM[i]) begin
                    bad++; $display("FAIL %s_cmd%0d: got %h want %h", name, i, cmd_log[base + i], EXP_NOM[i]);
                end
            end
        end
    endtask

    task automatic test_nominal();
        int base, n, rises;
        bit ok, prev;
        cfg_silent = 1'b0; cfg_echo = 8'hAA; cfg_busy_cnt = 2;
        base = cmd_log.size();
        pulse_start();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL start_busy: got %b want 1", busy); end
        n = 0;
        while (sd_sclk !== 1'b1 && n < 50) begin @(negedge CLOCK_50); n++; end
        total++; if (n != CLK_DIV + 1) begin bad++; $display("FAIL first_rise: got %0d cycles want %0d", n, CLK_DIV + 1); end
        rises = 1; prev = 1'b1;
        for (int k = 0; k < 5000 && sd_cs_n; k++) begin
            @(negedge CLOCK_50);
            if (sd_sclk && !prev) rises++;
            prev = sd_sclk;
        end
        total++; if (rises != 80) begin bad++; $display("FAIL dummy_clocks: got %0d want 80", rises); end
        wait_idle(ok);
        total++; if (!ok) begin bad++; $display("FAIL nominal_timeout: busy stuck got 1 want 0"); end
        check_cmds("nominal", base, 8);
        total++; if ({init_done, init_err, err_code} !== 5'b10_000) begin bad++; $display("FAIL nominal_flags: got %b want 10000", {init_done, init_err, err_code}); end
        total++; if (last_r1 !== 8'h00) begin bad++; $display("FAIL nominal_last_r1: got %h want 00", last_r1); end
        total++; if ({sd_cs_n, sd_sclk} !== 2'b10) begin bad++; $display("FAIL nominal_pins: got %b want 10", {sd_cs_n, sd_sclk}); end
    endtask

    task automatic test_silent();
        int base, lo0;
        bit ok;
        cfg_silent = 1'b1;
        base = cmd_log.size(); lo0 = lo_rises;
        pulse_start();
        wait_idle(ok);
        total++; if (!ok) begin bad++; $display("FAIL silent_timeout: busy stuck got 1 want 0"); end
        total++; if ({init_done, init_err, err_code} !== 5'b01_110) begin bad++; $display("FAIL silent_flags: got %b want 01110", {init_done, init_err, err_code}); end
        total++; if (lo_rises - lo0 != 176) begin bad++; $display("FAIL silent_cs_low_clocks: got %0d want 176", lo_rises - lo0); end
        total++; if ({busy, sd_cs_n} !== 2'b01) begin bad++; $display("FAIL silent_pins: got %b want 01", {busy, sd_cs_n}); end
        check_cmds("silent", base, 1);
        total++; if (last_r1 !== 8'h00) begin bad++; $display("FAIL silent_last_r1: got %h want 00", last_r1); end
        cfg_silent = 1'b0;
    endtask

    task automatic test_bad_r7();
        int base;
        bit ok;
        cfg_echo = 8'h55;
        base = cmd_log.size();
        pulse_start();
        wait_idle(ok);
        total++; if (!ok) begin bad++; $display("FAIL bad_r7_timeout: busy stuck got 1 want 0"); end
        total++; if ({init_done, init_err, err_code} !== 5'b01_011) begin bad++; $display("FAIL bad_r7_flags: got %b want 01011", {init_done, init_err, err_code}); end
        total++; if (last_r1 !== 8'h01) begin bad++; $display("FAIL bad_r7_last_r1: got %h want 01", last_r1); end
        check_cmds("bad_r7", base, 2);
        cfg_echo = 8'hAA;
    endtask

    task automatic test_never_ready();
        int base;
        bit ok;
        cfg_busy_cnt = 1000;
        base = cmd_log.size();
        pulse_start();
        wait_idle(ok);
        total++; if (!ok) begin bad++; $display("FAIL never_ready_timeout: busy stuck got 1 want 0"); end
        total++; if ({init_done, init_err, err_code} !== 5'b01_101) begin bad++; $display("FAIL never_ready_flags: got %b want 01101", {init_done, init_err, err_code}); end
        check_cmds("never_ready", base, 8);
        total++; if (last_r1 !== 8'h01) begin bad++; $display("FAIL never_ready_last_r1: got %h want 01", last_r1); end
        cfg_busy_cnt = 2;
    endtask

    task automatic test_start_ignored();
        int base;
        bit ok, hit;
        base = cmd_log.size();
        pulse_start();
        hit = 1'b0;
        for (int n = 0; n < 20000; n++) begin
            @(negedge CLOCK_50);
            if (cmd_len == 2 && cmd_buf[15:8] == 8'h48) begin hit = 1'b1; break; end
        end
        total++; if (!hit) begin bad++; $display("FAIL mid_cmd8_reached: got 0 want 1"); end
        pulse_start();
        wait_idle(ok);
        total++; if (!ok) begin bad++; $display("FAIL ignored_timeout: busy stuck got 1 want 0"); end
        total++; if ({init_done, init_err, err_code} !== 5'b10_000) begin bad++; $display("FAIL ignored_flags: got %b want 10000", {init_done, init_err, err_code}); end
        check_cmds("ignored", base, 8);
    endtask

    task automatic test_reset_mid();
        bit hit;
        pulse_start();
        hit = 1'b0;
        for (int n = 0; n < 20000; n++) begin
            @(negedge CLOCK_50);
            if (cmd_len == 2 && cmd_buf[15:8] == 8'h69) begin hit = 1'b1; break; end
        end
        total++; if (!hit) begin bad++; $display("FAIL mid_acmd41_reached: got 0 want 1"); end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({sd_sclk, sd_cs_n, sd_mosi, busy, init_done, init_err, err_code, last_r1} !== {6'b011000, 3'd0, 8'hFF}) begin
            bad++; $display("FAIL async_reset: got %b want %b",
                {sd_sclk, sd_cs_n, sd_mosi, busy, init_done, init_err, err_code, last_r1}, {6'b011000, 3'd0, 8'hFF});
        end
        repeat (3) @(negedge CLOCK_50);
        rst_n = 1'b1;
    endtask

    task automatic test_rerun();
        int base, rises;
        bit ok, prev;
        base = cmd_log.size();
        pulse_start();
        rises = 0; prev = sd_sclk;
        for (int k = 0; k < 5000 && sd_cs_n; k++) begin
            @(negedge CLOCK_50);
            if (sd_sclk && !prev) rises++;
            prev = sd_sclk;
        end
        total++; if (rises != 80) begin bad++; $display("FAIL rerun_dummy_clocks: got %0d want 80", rises); end
        wait_idle(ok);
        total++; if (!ok) begin bad++; $display("FAIL rerun_timeout: busy stuck got 1 want 0"); end
        total++; if ({init_done, init_err, err_code} !== 5'b10_000) begin bad++; $display("FAIL rerun_flags: got %b want 10000", {init_done, init_err, err_code}); end
        total++; if (last_r1 !== 8'h00) begin bad++; $display("FAIL rerun_last_r1: got %h want 00", last_r1); end
        check_cmds("rerun", base, 8);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0;
        cfg_silent = 1'b0; cfg_echo = 8'hAA; cfg_busy_cnt = 2;
        test_reset();
        test_nominal();
        test_silent();
        test_bad_r7();
        test_never_ready();
        test_start_ignored();
        test_reset_mid();
        test_rerun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
